// File: rtl/ad56x3_pkg.sv
// Shared frame constants, command/address codes and receiver state encoding
// for the AD56x3 serial frame receiver.
package ad56x3_pkg;

    localparam int unsigned FRAME_BITS = 24;

    typedef enum logic [2:0] {
        CMD_WR_UPD_ALL = 3'b010,
        CMD_WR_UPD_N   = 3'b011
    } cmd_t;

    typedef enum logic [2:0] {
        ADDR_A   = 3'b000,
        ADDR_B   = 3'b001,
        ADDR_ALL = 3'b111
    } addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WAITHI,
        S_DECODE
    } state_t;

endpackage

// File: rtl/ad56x3_frame_rx_if.sv
// 3-wire DAC line bundle plus the recovered per-channel sample outputs.
interface ad56x3_frame_rx_if #(
    parameter int unsigned DATA_WIDTH = 14
);
    logic                  dacSync;
    logic                  dacSclk;
    logic                  dacDin;
    logic [DATA_WIDTH-1:0] dataA;
    logic [DATA_WIDTH-1:0] dataB;
    logic                  validA;
    logic                  validB;
    logic                  errFrame;
    logic                  errCmd;

    modport master (
        output dacSync, dacSclk, dacDin,
        input  dataA, dataB, validA, validB, errFrame, errCmd
    );

    modport slave (
        input  dacSync, dacSclk, dacDin,
        output dataA, dataB, validA, validB, errFrame, errCmd
    );
endinterface

// File: rtl/ad56x3_line_sync.sv
// 2-FF synchronizer for one asynchronous line plus a third stage for
// single-cycle rise/fall strobes.
module ad56x3_line_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic       s1, s2, s3;
    logic [2:0] primed;

    // Edges are only reported once all three stages hold real line samples,
    // so the reset fill value can never fake an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            s3     <= RESET_VAL;
            primed <= '0;
        end else begin
            s1     <= d;
            s2     <= s1;
            s3     <= s2;
            primed <= {primed[1:0], 1'b1};
        end
    end

    assign q    = s2;
    assign rise = primed[2] &  s2 & ~s3;
    assign fall = primed[2] & ~s2 &  s3;
endmodule

// File: rtl/ad56x3_frame_rx.sv
// AD56x3 3-wire frame receiver: oversamples sync/sclk/din, shifts 24-bit
// frames and decodes them into per-channel samples with valid/error pulses.
module ad56x3_frame_rx
    import ad56x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 14,
    parameter string       SIGN_A     = "UNSIGNED",
    parameter string       SIGN_B     = "UNSIGNED"
) (
    input  logic              clk,
    input  logic              reset,
    ad56x3_frame_rx_if.slave  bus
);
    localparam int unsigned      CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam bit               SGN_A    = (SIGN_A == "SIGNED");
    localparam bit               SGN_B    = (SIGN_B == "SIGNED");

    logic syncLvl, syncRise, syncFall;
    logic sclkLvl, sclkRise, sclkFall;
    logic din, dinRise, dinFall;

    ad56x3_line_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk(clk), .reset(reset), .d(bus.dacSync),
        .q(syncLvl), .rise(syncRise), .fall(syncFall)
    );
    ad56x3_line_sync #(.RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d(bus.dacSclk),
        .q(sclkLvl), .rise(sclkRise), .fall(sclkFall)
    );
    ad56x3_line_sync #(.RESET_VAL(1'b0)) u_din (
        .clk(clk), .reset(reset), .d(bus.dacDin),
        .q(din), .rise(dinRise), .fall(dinFall)
    );

    state_t                state, stateNxt;
    logic [CNT_W-1:0]      bitCnt, bitCntNxt;
    logic [FRAME_BITS-1:0] shreg, shregNxt;
    logic                  aUpd, bUpd, errFNxt, errCNxt;
    logic                  cmdOk, addrOk;
    logic [2:0]            cmd, addr;
    logic [DATA_WIDTH-1:0] sample, sampA, sampB;
    logic                  unused;

    assign unused = ^{sclkLvl, sclkRise, dinRise, dinFall, shreg[FRAME_BITS-1]};

    assign cmd    = shreg[21:19];
    assign addr   = shreg[18:16];
    assign sample = shreg[15 -: DATA_WIDTH];
    assign cmdOk  = (cmd == CMD_WR_UPD_N) || (cmd == CMD_WR_UPD_ALL);
    assign addrOk = (addr == ADDR_A) || (addr == ADDR_B) || (addr == ADDR_ALL);

    // Offset binary back to two's complement is a flip of the sample MSB.
    assign sampA = SGN_A ? {~sample[DATA_WIDTH-1], sample[DATA_WIDTH-2:0]} : sample;
    assign sampB = SGN_B ? {~sample[DATA_WIDTH-1], sample[DATA_WIDTH-2:0]} : sample;

    always_comb begin
        stateNxt  = state;
        bitCntNxt = bitCnt;
        shregNxt  = shreg;
        aUpd      = 1'b0;
        bUpd      = 1'b0;
        errFNxt   = 1'b0;
        errCNxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (syncFall) begin
                    stateNxt  = S_RECV;
                    bitCntNxt = '0;
                    shregNxt  = '0;
                end
            end
            S_RECV: begin
                // A rise aborts the frame even when it coincides with the 24th edge.
                if (syncRise) begin
                    errFNxt  = 1'b1;
                    stateNxt = S_IDLE;
                end else if (sclkFall) begin
                    shregNxt  = {shreg[FRAME_BITS-2:0], din};
                    bitCntNxt = bitCnt + 1'b1;
                    if (bitCnt == LAST_BIT) stateNxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmdOk && addrOk) begin
                    aUpd = (addr == ADDR_A) || (addr == ADDR_ALL);
                    bUpd = (addr == ADDR_B) || (addr == ADDR_ALL);
                end else begin
                    errCNxt = 1'b1;
                end
                stateNxt = syncLvl ? S_IDLE : S_WAITHI;
            end
            S_WAITHI: begin
                if (syncRise) stateNxt = S_IDLE;
            end
            default: stateNxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            bitCnt       <= '0;
            shreg        <= '0;
            bus.dataA    <= '0;
            bus.dataB    <= '0;
            bus.validA   <= 1'b0;
            bus.validB   <= 1'b0;
            bus.errFrame <= 1'b0;
            bus.errCmd   <= 1'b0;
        end else begin
            state        <= stateNxt;
            bitCnt       <= bitCntNxt;
            shreg        <= shregNxt;
            if (aUpd) bus.dataA <= sampA;
            if (bUpd) bus.dataB <= sampB;
            bus.validA   <= aUpd;
            bus.validB   <= bUpd;
            bus.errFrame <= errFNxt;
            bus.errCmd   <= errCNxt;
        end
    end
endmodule

// File: tb/tb_ad56x3_frame_rx.sv
// Directed frame vectors for ad56x3_frame_rx: an unsigned and a channel-A
// signed instance share one line stream.
module tb_ad56x3_frame_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sync = 1'b1;
    logic sclk = 1'b0;
    logic din = 1'b0;

    always #5 clk = ~clk;

    ad56x3_frame_rx_if #(.DATA_WIDTH(14)) ifU ();
    ad56x3_frame_rx_if #(.DATA_WIDTH(14)) ifS ();

    assign ifU.dacSync = sync;
    assign ifU.dacSclk = sclk;
    assign ifU.dacDin  = din;
    assign ifS.dacSync = sync;
    assign ifS.dacSclk = sclk;
    assign ifS.dacDin  = din;

    ad56x3_frame_rx #(.DATA_WIDTH(14), .SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED")) dutU (
        .clk(clk), .reset(reset), .bus(ifU)
    );
    ad56x3_frame_rx #(.DATA_WIDTH(14), .SIGN_A("SIGNED"), .SIGN_B("UNSIGNED")) dutS (
        .clk(clk), .reset(reset), .bus(ifS)
    );

    // Free-running pulse counters of the unsigned instance; pulses longer
    // than one cycle count more than once.
    int cvA = 0, cvB = 0, cEF = 0, cEC = 0;
    always @(negedge clk) begin
        cvA += int'(ifU.validA);
        cvB += int'(ifU.validB);
        cEF += int'(ifU.errFrame);
        cEC += int'(ifU.errCmd);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sclk = 1'b1;
        din  = b;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // mode 1: the last falling sclk edge coincides with sync rising
    task automatic send(input logic [23:0] f, input int nbits, input int mode);
        @(negedge clk);
        sync = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (mode == 1 && i == nbits - 1) begin
                sclk = 1'b1;
                din  = f[23-i];
                repeat (2) @(negedge clk);
                sclk = 1'b0;
                sync = 1'b1;
                repeat (2) @(negedge clk);
            end else begin
                bit_out((i < 24) ? f[23-i] : 1'b1);
            end
        end
        repeat (2) @(negedge clk);
        sync = 1'b1;
        din  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        int          mode;
        logic [13:0] expA;
        logic [13:0] expB;
        logic [13:0] expSA;
        int          nvA;
        int          nvB;
        int          nEF;
        int          nEC;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int bvA, bvB, bEF, bEC;

        vecs[0]  = '{24'h18FFFC, 24, 0, 14'h3FFF, 14'h0000, 14'h1FFF, 1, 0, 0, 0};
        vecs[1]  = '{24'h19A5A4, 24, 0, 14'h3FFF, 14'h2969, 14'h1FFF, 0, 1, 0, 0};
        vecs[2]  = '{24'h1F0004, 24, 0, 14'h0001, 14'h0001, 14'h2001, 1, 1, 0, 0};
        vecs[3]  = '{24'h188000, 24, 0, 14'h2000, 14'h0001, 14'h0000, 1, 0, 0, 0};
        vecs[4]  = '{24'h180000, 24, 0, 14'h0000, 14'h0001, 14'h2000, 1, 0, 0, 0};
        vecs[5]  = '{24'h18FFFC, 10, 0, 14'h0000, 14'h0001, 14'h2000, 0, 0, 1, 0};
        vecs[6]  = '{24'h181234, 24, 0, 14'h048D, 14'h0001, 14'h248D, 1, 0, 0, 0};
        vecs[7]  = '{24'h200000, 24, 0, 14'h048D, 14'h0001, 14'h248D, 0, 0, 0, 1};
        vecs[8]  = '{24'h1A1234, 24, 0, 14'h048D, 14'h0001, 14'h248D, 0, 0, 0, 1};
        vecs[9]  = '{24'h18FFFC, 30, 0, 14'h3FFF, 14'h0001, 14'h1FFF, 1, 0, 0, 0};
        vecs[10] = '{24'h181234, 30, 0, 14'h048D, 14'h0001, 14'h248D, 1, 0, 0, 0};
        vecs[11] = '{24'h19FFFC, 24, 1, 14'h048D, 14'h0001, 14'h248D, 0, 0, 1, 0};
        vecs[12] = '{24'h1F0000, 24, 0, 14'h0000, 14'h0000, 14'h2000, 1, 1, 0, 0};
        vecs[13] = '{24'h11FFFC, 24, 0, 14'h0000, 14'h3FFF, 14'h2000, 0, 1, 0, 0};
        vecs[14] = '{24'h170008, 24, 0, 14'h0002, 14'h0002, 14'h2002, 1, 1, 0, 0};
        vecs[15] = '{24'hD8FFFC, 24, 0, 14'h3FFF, 14'h0002, 14'h1FFF, 1, 0, 0, 0};
        vecs[16] = '{24'h1D0004, 24, 0, 14'h3FFF, 14'h0002, 14'h1FFF, 0, 0, 0, 1};

        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst dataA", 32'(ifU.dataA), 0);
        chk("rst dataB", 32'(ifU.dataB), 0);
        chk("rst validA", 32'(ifU.validA), 0);
        chk("rst validB", 32'(ifU.validB), 0);
        chk("rst errFrame", 32'(ifU.errFrame), 0);
        chk("rst errCmd", 32'(ifU.errCmd), 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            bvA = cvA; bvB = cvB; bEF = cEF; bEC = cEC;
            send(vecs[i].frame, vecs[i].nbits, vecs[i].mode);
            chk($sformatf("v%0d dataA", i), 32'(ifU.dataA), 32'(vecs[i].expA));
            chk($sformatf("v%0d dataB", i), 32'(ifU.dataB), 32'(vecs[i].expB));
            chk($sformatf("v%0d signed dataA", i), 32'(ifS.dataA), 32'(vecs[i].expSA));
            chk($sformatf("v%0d validA pulses", i), cvA - bvA, vecs[i].nvA);
            chk($sformatf("v%0d validB pulses", i), cvB - bvB, vecs[i].nvB);
            chk($sformatf("v%0d errFrame pulses", i), cEF - bEF, vecs[i].nEF);
            chk($sformatf("v%0d errCmd pulses", i), cEC - bEC, vecs[i].nEC);
        end

        // Reset in the middle of a frame, released with sync still low.
        @(negedge clk);
        sync = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) bit_out(1'b1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst dataA", 32'(ifU.dataA), 0);
        chk("midrst dataB", 32'(ifU.dataB), 0);
        chk("midrst signed dataA", 32'(ifS.dataA), 0);
        chk("midrst validA", 32'(ifU.validA), 0);
        chk("midrst errFrame", 32'(ifU.errFrame), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bvA = cvA; bvB = cvB; bEF = cEF; bEC = cEC;
        for (int i = 0; i < 12; i++) bit_out(1'b0);
        repeat (2) @(negedge clk);
        sync = 1'b1;
        repeat (8) @(negedge clk);
        chk("after-rst dataA", 32'(ifU.dataA), 0);
        chk("after-rst valid pulses", (cvA - bvA) + (cvB - bvB), 0);
        chk("after-rst err pulses", (cEF - bEF) + (cEC - bEC), 0);

        bvA = cvA; bvB = cvB; bEF = cEF; bEC = cEC;
        send(24'h181234, 24, 0);
        chk("clean dataA", 32'(ifU.dataA), 32'h048D);
        chk("clean dataB", 32'(ifU.dataB), 0);
        chk("clean validA pulses", cvA - bvA, 1);
        chk("clean validB pulses", cvB - bvB, 0);
        chk("clean err pulses", (cEF - bEF) + (cEC - bEC), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
